dll_rx_demux_pipe: RTL and testbench

//  Registered, parametrised DLL receive demultiplexer. Splits the framed beat stream from the RX physical

---
 rtl/dll_pkg.sv | 9 +
 rtl/dll_rx_demux_pipe_if.sv | 35 +++
 rtl/dll_skid_buf.sv | 49 ++++
 rtl/dll_rx_demux_pipe.sv | 163 ++++++++++++++++
 tb/tb_dll_rx_demux_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dll_pkg.sv
// Shared constants and enumerations for the DLL receive demultiplexer.
package dll_pkg;
  localparam int TLP_OVH  = 6;
  localparam int DLLP_LEN = 6;

  typedef enum logic {PKT_DLLP = 1'b0, PKT_TLP = 1'b1} pkt_type_t;

  typedef enum logic [1:0] {ST_IDLE, ST_IN_TLP, ST_DROP} rx_dmx_st_t;
endpackage

// File: rtl/dll_rx_demux_pipe_if.sv
// Beat-stream bundle for the DLL RX demux: framed input plus TLP and DLLP output streams.
interface dll_rx_demux_pipe_if #(
  parameter int DATA_W = 128,
  parameter int DLLP_W = 64,
  parameter int LEN_W  = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;
  logic              in_type;
  logic [LEN_W-1:0]  in_len;
  logic              in_end;

  logic [DATA_W-1:0] tlp_data;
  logic              tlp_vld;
  logic              tlp_rdy;
  logic [LEN_W-1:0]  tlp_len;
  logic              tlp_end;

  logic [DLLP_W-1:0] dllp_data;
  logic              dllp_vld;
  logic              dllp_rdy;
  logic [LEN_W-1:0]  dllp_len;

  // Environment side: produces the framed stream and consumes both output streams.
  modport master (
    output in_data, in_vld, in_type, in_len, in_end, tlp_rdy, dllp_rdy,
    input  in_rdy, tlp_data, tlp_vld, tlp_len, tlp_end, dllp_data, dllp_vld, dllp_len
  );

  modport slave (
    input  in_data, in_vld, in_type, in_len, in_end, tlp_rdy, dllp_rdy,
    output in_rdy, tlp_data, tlp_vld, tlp_len, tlp_end, dllp_data, dllp_vld, dllp_len
  );
endinterface

// File: rtl/dll_skid_buf.sv
// Two-entry valid/ready skid buffer: registered output, registered push_rdy, full throughput.
module dll_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_data,
  input  logic         pop_rdy
);
  logic         out_vld_p1;
  logic         skid_vld_p1;
  logic         rdy_p1;
  logic [W-1:0] out_data_p1;
  logic [W-1:0] skid_data_p1;
  logic         acc_p0;
  logic         load_out_p0;

  assign acc_p0      = push & rdy_p1;
  assign load_out_p0 = ~out_vld_p1 | pop_rdy;

  // Output register refills from the skid entry first; ready only when the skid entry is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_p1  <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
    end else if (load_out_p0) begin
      out_vld_p1  <= skid_vld_p1 | acc_p0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
    end else begin
      if (acc_p0) skid_vld_p1 <= 1'b1;
      rdy_p1 <= ~(skid_vld_p1 | acc_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (load_out_p0) out_data_p1 <= skid_vld_p1 ? skid_data_p1 : push_data;
    if (!load_out_p0 && acc_p0) skid_data_p1 <= push_data;
  end

  assign push_rdy = rdy_p1;
  assign pop_vld  = out_vld_p1;
  assign pop_data = out_data_p1;
endmodule

// File: rtl/dll_rx_demux_pipe.sv
// DLL receive demux: splits framed beats into TLP and DLLP streams, drops malformed packets, keeps stats.
module dll_rx_demux_pipe #(
  parameter int DATA_W   = 128,
  parameter int DLLP_W   = 64,
  parameter int LEN_W    = 6,
  parameter int TLP_OVH  = dll_pkg::TLP_OVH,
  parameter int DLLP_LEN = dll_pkg::DLLP_LEN,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dll_rx_demux_pipe_if.slave   bus,
  output logic                 err_short,
  output logic                 err_interleave,
  output logic [CNT_W-1:0]     tlp_cnt,
  output logic [CNT_W-1:0]     dllp_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);
  import dll_pkg::*;

  localparam int               TW         = DATA_W + LEN_W + 1;
  localparam logic [LEN_W-1:0] OVH_L      = LEN_W'(TLP_OVH);
  localparam logic [LEN_W-1:0] DLLP_LEN_L = LEN_W'(DLLP_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  rx_dmx_st_t       st_p0;
  rx_dmx_st_t       st_nxt_p0;
  logic [LEN_W-1:0] len_p0;
  logic [LEN_W-1:0] tlp_len_sel_p0;
  logic             tlp_buf_rdy;
  logic             dllp_buf_rdy;
  logic             acc_p0;
  logic             is_tlp_p0;
  logic             is_short_p0;
  logic             tlp_push_p0;
  logic             dllp_push_p0;
  logic             len_ld_p0;
  logic             inc_tlp_p0;
  logic             inc_dllp_p0;
  logic             inc_drop_p0;
  logic             ev_short_p0;
  logic             ev_il_p0;

  logic             tlp_vld_p1;
  logic [TW-1:0]    tlp_word_p1;
  logic             dllp_vld_p1;
  logic [DLLP_W-1:0] dllp_word_p1;

  assign bus.in_rdy  = tlp_buf_rdy & dllp_buf_rdy;
  assign acc_p0      = bus.in_vld & bus.in_rdy;
  assign is_tlp_p0   = pkt_type_t'(bus.in_type) == PKT_TLP;
  assign is_short_p0 = bus.in_len <= OVH_L;

  always_comb begin
    st_nxt_p0      = st_p0;
    tlp_push_p0    = 1'b0;
    dllp_push_p0   = 1'b0;
    len_ld_p0      = 1'b0;
    tlp_len_sel_p0 = len_p0;
    inc_tlp_p0     = 1'b0;
    inc_dllp_p0    = 1'b0;
    inc_drop_p0    = 1'b0;
    ev_short_p0    = 1'b0;
    ev_il_p0       = 1'b0;
    if (acc_p0) begin
      case (st_p0)
        ST_IDLE: begin
          if (!is_tlp_p0) begin
            dllp_push_p0 = 1'b1;
            inc_dllp_p0  = 1'b1;
          end else if (is_short_p0) begin
            ev_short_p0 = 1'b1;
            if (bus.in_end) inc_drop_p0 = 1'b1;
            else            st_nxt_p0   = ST_DROP;
          end else begin
            tlp_push_p0    = 1'b1;
            len_ld_p0      = 1'b1;
            tlp_len_sel_p0 = bus.in_len - OVH_L;
            if (bus.in_end) inc_tlp_p0 = 1'b1;
            else            st_nxt_p0  = ST_IN_TLP;
          end
        end
        ST_IN_TLP: begin
          if (is_tlp_p0) begin
            tlp_push_p0 = 1'b1;
            if (bus.in_end) begin
              inc_tlp_p0 = 1'b1;
              st_nxt_p0  = ST_IDLE;
            end
          end else begin
            ev_il_p0    = 1'b1;
            inc_drop_p0 = 1'b1;
          end
        end
        ST_DROP: begin
          // DLLPs seen while discarding a short TLP vanish without being counted.
          if (is_tlp_p0 && bus.in_end) begin
            inc_drop_p0 = 1'b1;
            st_nxt_p0   = ST_IDLE;
          end
        end
        default: st_nxt_p0 = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_p0          <= ST_IDLE;
      err_short      <= 1'b0;
      err_interleave <= 1'b0;
      tlp_cnt        <= '0;
      dllp_cnt       <= '0;
      drop_cnt       <= '0;
    end else begin
      st_p0          <= st_nxt_p0;
      err_short      <= ev_short_p0;
      err_interleave <= ev_il_p0;
      tlp_cnt        <= sat_inc(tlp_cnt, inc_tlp_p0);
      dllp_cnt       <= sat_inc(dllp_cnt, inc_dllp_p0);
      drop_cnt       <= sat_inc(drop_cnt, inc_drop_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (len_ld_p0) len_p0 <= tlp_len_sel_p0;
  end

  // Output stage: skid buffers isolate consumer ready from in_rdy.
  dll_skid_buf #(.W(TW)) u_tlp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (tlp_push_p0),
    .push_data ({tlp_len_sel_p0, bus.in_end, bus.in_data}),
    .push_rdy  (tlp_buf_rdy),
    .pop_vld   (tlp_vld_p1),
    .pop_data  (tlp_word_p1),
    .pop_rdy   (bus.tlp_rdy)
  );

  dll_skid_buf #(.W(DLLP_W)) u_dllp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (dllp_push_p0),
    .push_data (bus.in_data[DATA_W-1 -: DLLP_W]),
    .push_rdy  (dllp_buf_rdy),
    .pop_vld   (dllp_vld_p1),
    .pop_data  (dllp_word_p1),
    .pop_rdy   (bus.dllp_rdy)
  );

  // Data registers are not reset, so side-band fields are masked with valid to read zero when idle.
  assign bus.tlp_vld   = tlp_vld_p1;
  assign bus.tlp_data  = tlp_vld_p1 ? tlp_word_p1[DATA_W-1:0] : '0;
  assign bus.tlp_end   = tlp_vld_p1 & tlp_word_p1[DATA_W];
  assign bus.tlp_len   = tlp_vld_p1 ? tlp_word_p1[TW-1 -: LEN_W] : '0;
  assign bus.dllp_vld  = dllp_vld_p1;
  assign bus.dllp_data = dllp_vld_p1 ? dllp_word_p1 : '0;
  assign bus.dllp_len  = dllp_vld_p1 ? DLLP_LEN_L : '0;
endmodule

// File: tb/tb_dll_rx_demux_pipe.sv
// Scoreboard bench for dll_rx_demux_pipe: directed cases plus randomized packet traffic.
module tb_dll_rx_demux_pipe;
  localparam int DW = 128;
  localparam int LW = 6;
  localparam int CW = 16;
  typedef logic [DW+LW:0] tbeat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_short, err_interleave;
  logic [CW-1:0] tlp_cnt, dllp_cnt, drop_cnt;

  dll_rx_demux_pipe_if #(.DATA_W(DW), .DLLP_W(64), .LEN_W(LW)) bus ();

  dll_rx_demux_pipe #(
    .DATA_W(DW), .DLLP_W(64), .LEN_W(LW), .TLP_OVH(6), .DLLP_LEN(6), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .err_short(err_short), .err_interleave(err_interleave),
    .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: packet-level rules, updated whenever a beat is handed over.
  tbeat_t      tq[$];
  logic [63:0] dq[$];
  int          m_tlp, m_dllp, m_drop;
  bit          pkt_open, pkt_bad;
  logic [5:0]  pkt_len;
  bit          exp_short, exp_il, ev;

  function automatic int sat(input int c);
    return (c >= (1 << CW) - 1) ? c : c + 1;
  endfunction

  always @(negedge clk) begin
    exp_short = 0; exp_il = 0; ev = 0;
    if (rst) begin
      tq.delete(); dq.delete();
      m_tlp = 0; m_dllp = 0; m_drop = 0;
      pkt_open = 0; pkt_bad = 0;
    end else if (bus.in_vld && bus.in_rdy) begin
      ev = 1;
      if (bus.in_type) begin
        if (pkt_bad) begin
          if (bus.in_end) begin pkt_bad = 0; m_drop = sat(m_drop); end
        end else if (!pkt_open && bus.in_len <= 6) begin
          exp_short = 1;
          if (bus.in_end) m_drop = sat(m_drop); else pkt_bad = 1;
        end else begin
          if (!pkt_open) pkt_len = bus.in_len - 6'd6;
          tq.push_back({bus.in_data, pkt_len, bus.in_end});
          pkt_open = !bus.in_end;
          if (bus.in_end) m_tlp = sat(m_tlp);
        end
      end else if (pkt_open) begin
        exp_il = 1; m_drop = sat(m_drop);
      end else if (!pkt_bad) begin
        dq.push_back(bus.in_data[127:64]);
        m_dllp = sat(m_dllp);
      end
    end
  end

  // Consumer ready generation: 0 = always ready, 1 = random, 2 = stalled.
  int tlp_rdy_mode = 0;
  int dllp_rdy_mode = 0;

  initial begin
    bus.tlp_rdy = 1'b0;
    bus.dllp_rdy = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.tlp_rdy  = rst ? 1'b0 : (tlp_rdy_mode == 0) ? 1'b1 :
                     (tlp_rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      bus.dllp_rdy = rst ? 1'b0 : (dllp_rdy_mode == 0) ? 1'b1 :
                     (dllp_rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks side effects.
  bit        hold_chk = 0;
  logic [DW-1:0] hold_data;
  tbeat_t    te;
  logic [63:0] de;

  initial begin
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        hold_chk = 0;
      end else begin
        if (hold_chk) chk("tlp_hold", 160'({bus.tlp_vld, bus.tlp_data}), 160'({1'b1, hold_data}));
        hold_chk  = bus.tlp_vld && !bus.tlp_rdy;
        hold_data = bus.tlp_data;
        if (bus.tlp_vld && bus.tlp_rdy) begin
          if (tq.size() == 0) chk("tlp_unexpected", 160'({bus.tlp_data, bus.tlp_len, bus.tlp_end}), 160'(0));
          else begin
            te = tq.pop_front();
            chk("tlp_beat", 160'({bus.tlp_data, bus.tlp_len, bus.tlp_end}), 160'(te));
          end
        end
        if (bus.dllp_vld && bus.dllp_rdy) begin
          if (dq.size() == 0) chk("dllp_unexpected", 160'({bus.dllp_data, bus.dllp_len}), 160'(0));
          else begin
            de = dq.pop_front();
            chk("dllp_beat", 160'({bus.dllp_data, bus.dllp_len}), 160'({de, 6'd6}));
          end
        end
        if (err_short || exp_short) chk("err_short", 160'(err_short), 160'(exp_short));
        if (err_interleave || exp_il) chk("err_interleave", 160'(err_interleave), 160'(exp_il));
        if (ev) begin
          chk("tlp_cnt", 160'(tlp_cnt), 160'(m_tlp));
          chk("dllp_cnt", 160'(dllp_cnt), 160'(m_dllp));
          chk("drop_cnt", 160'(drop_cnt), 160'(m_drop));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_beat(input logic t, input logic [LW-1:0] l, input logic e, input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.in_vld = 1'b1; bus.in_type = t; bus.in_len = l; bus.in_end = e; bus.in_data = d;
    forever begin
      @(negedge clk);
      if (bus.in_rdy) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 160'(bus.in_rdy), 160'(1));
        break;
      end
    end
    step();
    bus.in_vld = 1'b0;
  endtask

  task automatic send_tlp(input logic [LW-1:0] l, input int nb);
    for (int b = 0; b < nb; b++) send_beat(1'b1, (b == 0) ? l : LW'($urandom), b == nb - 1, rand128());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_vld = 1'b0;
    step(); step();
    chk("rst_tlp_out", 160'({bus.tlp_vld, bus.tlp_data, bus.tlp_len, bus.tlp_end}), 160'(0));
    chk("rst_dllp_out", 160'({bus.dllp_vld, bus.dllp_data, bus.dllp_len}), 160'(0));
    chk("rst_ctl", 160'({bus.in_rdy, err_short, err_interleave}), 160'(0));
    chk("rst_cnt", 160'({tlp_cnt, dllp_cnt, drop_cnt}), 160'(0));
    rst = 1'b0;
    step();
  endtask

  task automatic drain();
    tlp_rdy_mode = 0; dllp_rdy_mode = 0;
    for (int i = 0; i < 200 && (tq.size() != 0 || dq.size() != 0); i++) step();
    step(); step();
    chk("drain_empty", 160'({tq.size(), dq.size()}), 160'(0));
  endtask

  task automatic rand_pkt();
    int nb;
    logic [LW-1:0] l;
    if ($urandom_range(0, 9) < 3) begin
      send_beat(1'b0, LW'($urandom), 1'($urandom), rand128());
    end else begin
      nb = $urandom_range(1, 4);
      l = ($urandom_range(0, 4) == 0) ? LW'($urandom_range(0, 7)) : LW'($urandom);
      for (int b = 0; b < nb; b++) begin
        send_beat(1'b1, (b == 0) ? l : LW'($urandom), b == nb - 1, rand128());
        if (b < nb - 1 && $urandom_range(0, 9) == 0) send_beat(1'b0, 6'd6, 1'b1, rand128());
        if ($urandom_range(0, 3) == 0) step();
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int lowat;
    bus.in_vld = 1'b0; bus.in_type = 1'b0; bus.in_len = '0; bus.in_end = 1'b0; bus.in_data = '0;
    @(posedge clk); #1;
    do_reset();

    // Single DLLP with a recognisable upper half.
    send_beat(1'b0, 6'd6, 1'b0, {64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF});
    drain();
    chk("t1_dllp_cnt", 160'(dllp_cnt), 160'(1));

    do_reset();
    send_tlp(6'd30, 3);
    drain();
    chk("t2_tlp_cnt", 160'({tlp_cnt, drop_cnt}), 160'({16'd1, 16'd0}));

    do_reset();
    send_tlp(6'd6, 2);
    send_beat(1'b0, 6'd6, 1'b1, rand128());
    drain();
    chk("t3_counts", 160'({tlp_cnt, dllp_cnt, drop_cnt}), 160'({16'd0, 16'd1, 16'd1}));

    do_reset();
    send_beat(1'b1, 6'd20, 1'b0, rand128());
    send_beat(1'b0, 6'd6, 1'b1, rand128());
    send_beat(1'b1, 6'd0, 1'b1, rand128());
    drain();
    chk("t4_counts", 160'({tlp_cnt, dllp_cnt, drop_cnt}), 160'({16'd1, 16'd0, 16'd1}));

    do_reset();
    fork
      send_tlp(6'd40, 8);
      begin
        lowat = -1;
        step();
        tlp_rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
          step();
          if (!bus.in_rdy && lowat < 0) lowat = i;
        end
        chk("t5_in_rdy_fall", 160'(lowat >= 0 && lowat <= 2), 160'(1));
        tlp_rdy_mode = 0;
      end
    join
    drain();
    chk("t5_tlp_cnt", 160'(tlp_cnt), 160'(1));

    do_reset();
    tlp_rdy_mode = 2;
    send_tlp(6'd50, 2);
    do_reset();
    tlp_rdy_mode = 0;
    send_beat(1'b0, 6'd6, 1'b1, rand128());
    drain();
    chk("t6_counts", 160'({tlp_cnt, dllp_cnt, drop_cnt}), 160'({16'd0, 16'd1, 16'd0}));

    do_reset();
    for (int p = 0; p < 400; p++) begin
      if (p % 50 == 0) begin
        tlp_rdy_mode = $urandom_range(0, 1);
        dllp_rdy_mode = $urandom_range(0, 1);
      end
      rand_pkt();
    end
    drain();
    chk("final_cnt", 160'({tlp_cnt, dllp_cnt, drop_cnt}),
        160'({16'(m_tlp), 16'(m_dllp), 16'(m_drop)}));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
